// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control FSM: fetch/decode/execute sequencing, NZCV flag register, condition check.
// Latency 3-5 cycles per instruction (2 when the condition fails); no backpressure, steps every cycle.
module multicycle_ctrl #(
  parameter bit         ENABLE_CMP = 1'b1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemW,
  output logic        IRWrite,
  output logic        RegW,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic [1:0]  op;
  logic [3:0]  cmd;
  logic        sbit;
  logic        alu_ok;
  logic        is_cmp;
  logic [1:0]  alu_ctl;
  logic [1:0]  flagw;
  logic        cond_ex;
  logic        pcwrite_i, irwrite_i, regw_i, memw_i;
  logic        unused_instr;

  assign op   = Instr[27:26];
  assign cmd  = Instr[24:21];
  assign sbit = Instr[20];
  assign unused_instr = &{1'b0, Instr[19:0]};

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01) & ~sbit, op == 2'b10};
  assign Flags  = flags_q;
  assign State  = state_q;

  // ALU decode; flagw[1] covers N,Z and flagw[0] covers C,V
  always_comb begin
    alu_ok  = 1'b1;
    is_cmp  = 1'b0;
    alu_ctl = 2'b00;
    flagw   = 2'b00;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; flagw = {sbit, sbit}; end
      4'b0010: begin alu_ctl = 2'b01; flagw = {sbit, sbit}; end
      4'b0000: begin alu_ctl = 2'b10; flagw = {sbit, 1'b0}; end
      4'b1100: begin alu_ctl = 2'b11; flagw = {sbit, 1'b0}; end
      4'b1010: begin
        if (sbit && ENABLE_CMP) begin
          alu_ctl = 2'b01;
          is_cmp  = 1'b1;
          flagw   = 2'b11;
        end else begin
          alu_ok = 1'b0;
        end
      end
      default: alu_ok = 1'b0;
    endcase
  end

  // Condition check against registered flags: {N,Z,C,V} = flags_q[3:0]
  always_comb begin
    cond_ex = 1'b0;
    case (Instr[31:28])
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = flags_q[3] == flags_q[0];
      4'b1011: cond_ex = flags_q[3] != flags_q[0];
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      flags_q <= FLAG_RESET;
    end else begin
      state_q <= state_d;
      if (state_q == EXECUTER || state_q == EXECUTEI) begin
        if (flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_d    = FETCH;
    pcwrite_i  = 1'b0;
    irwrite_i  = 1'b0;
    regw_i     = 1'b0;
    memw_i     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite_i = 1'b1;
        pcwrite_i = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (cond_ex) begin
          case (op)
            2'b00:   state_d = Instr[25] ? EXECUTEI : EXECUTER;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = sbit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_i    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memw_i = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        state_d    = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        // Unsupported commands still pass through ALUWB but never write back
        regw_i = alu_ok;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcwrite_i = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign PCWrite = pcwrite_i & ~Reset;
  assign IRWrite = irwrite_i & ~Reset;
  assign RegW    = regw_i & ~Reset;
  assign MemW    = memw_i & ~Reset;

endmodule
